// File: rtl/shift_register_arbiter_if.sv
// shift_register_arbiter_if
//   Bundles the two requester streams, the ShiftRegister drive/return
//   signals and the tagged output stream of shift_register_arbiter.
//   Ports (signals):
//     a_valid/a_data/a_last/a_ready  requester A byte stream
//     b_valid/b_data/b_last/b_ready  requester B byte stream
//     sr_enable/sr_data_in           drive to ShiftRegister enable/dataIn
//     sr_data_out                    return from ShiftRegister dataOut
//     out_valid/out_data/out_id/out_last  tagged bytes leaving the register
//     busy                           arbiter or pipeline still active
//   Modports: master = sources + ShiftRegister side, slave = arbiter.
interface shift_register_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;
  logic             sr_enable;
  logic [WIDTH-1:0] sr_data_in;
  logic [WIDTH-1:0] sr_data_out;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_last;
  logic             busy;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, sr_data_out,
    input  a_ready, b_ready, sr_enable, sr_data_in,
           out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, sr_data_out,
    output a_ready, b_ready, sr_enable, sr_data_in,
           out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/shift_register_arbiter.sv
// shift_register_arbiter
//   Packet-level round-robin arbiter between two byte streams feeding an
//   external DEPTH-stage ShiftRegister. One requester owns the register for
//   a whole packet; after the last beat the register is flushed with zeros
//   for DEPTH cycles so every byte of the packet is shifted out and reported
//   with its owner id and last flag.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  shift_register_arbiter_if.slave (streams, register drive, output)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no packet owned; picks a requester when any valid is high
//   STREAM  | granted requester readied, accepted beats shift in
//   FLUSH   | zeros shifted in for DEPTH cycles to drain the packet
module shift_register_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  shift_register_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_grant;
  logic             r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] r_tag_v;
  logic [DEPTH-1:0] r_tag_id;
  logic [DEPTH-1:0] r_tag_last;
  logic             r_fresh;

  logic             w_any_req;
  logic             w_idle_pick;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;
  logic             w_beat;
  logic             w_flush_done;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_sr_enable;
  logic [WIDTH-1:0] w_sr_data_in;
  logic             w_out_valid;

  assign w_any_req    = bus.a_valid | bus.b_valid;
  // Contention goes to the pointer; a lone requester wins outright.
  assign w_idle_pick  = (bus.a_valid & bus.b_valid) ? r_rr_ptr : bus.b_valid;
  assign w_sel_valid  = r_grant ? bus.b_valid : bus.a_valid;
  assign w_sel_data   = r_grant ? bus.b_data  : bus.a_data;
  assign w_sel_last   = r_grant ? bus.b_last  : bus.a_last;
  assign w_beat       = (r_state == S_STREAM) & w_sel_valid;
  assign w_flush_done = (r_cnt == CW'(DEPTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next_state = S_STREAM;
      S_STREAM: if (w_beat && w_sel_last) w_next_state = S_FLUSH;
      S_FLUSH:  if (w_flush_done) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output logic: readies come from registered state only, the register
  // drive follows the granted valid/data combinationally.
  always_comb begin
    w_a_ready    = 1'b0;
    w_b_ready    = 1'b0;
    w_sr_enable  = 1'b0;
    w_sr_data_in = '0;
    case (r_state)
      S_STREAM: begin
        w_a_ready    = ~r_grant;
        w_b_ready    = r_grant;
        w_sr_enable  = w_sel_valid;
        w_sr_data_in = w_sel_valid ? w_sel_data : '0;
      end
      S_FLUSH: begin
        w_sr_enable = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant, round-robin pointer and flush counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant  <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_grant <= w_idle_pick;
      end
      if (w_beat && w_sel_last) begin
        r_cnt <= '0;
      end else if (r_state == S_FLUSH) begin
        r_cnt <= w_flush_done ? '0 : r_cnt + 1'b1;
      end
      if (r_state == S_FLUSH && w_flush_done) begin
        r_rr_ptr <= ~r_grant;
      end
    end
  end

  // Tag pipe mirrors the external register stage-for-stage. Flush cycles
  // load empty tags, so the zero padding is never reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_tag_last <= '0;
      r_fresh    <= 1'b0;
    end else begin
      r_fresh <= w_sr_enable;
      if (w_sr_enable) begin
        r_tag_v    <= {r_tag_v[DEPTH-2:0],    w_beat};
        r_tag_id   <= {r_tag_id[DEPTH-2:0],   w_beat & r_grant};
        r_tag_last <= {r_tag_last[DEPTH-2:0], w_beat & w_sel_last};
      end
    end
  end

  // A held (stalled) stage is not fresh, which prevents double reporting.
  assign w_out_valid    = r_tag_v[DEPTH-1] & r_fresh;

  assign bus.a_ready    = w_a_ready;
  assign bus.b_ready    = w_b_ready;
  assign bus.sr_enable  = w_sr_enable;
  assign bus.sr_data_in = w_sr_data_in;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = bus.sr_data_out;
  assign bus.out_id     = w_out_valid & r_tag_id[DEPTH-1];
  assign bus.out_last   = w_out_valid & r_tag_last[DEPTH-1];
  assign bus.busy       = (r_state != S_IDLE) | (|r_tag_v);
endmodule
